// File: rtl/cnn_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : cnn_cmd_master
// Purpose  : Initiator for the CNN command/stream protocol: frames operand
//            bursts to the accelerator and returns its result stream.
// Options  : CNN_MASTER_RSP_SUM_EN adds the rsp_sum output.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_cmd_master #(
    parameter int TIMEOUT = 4096,
    parameter int GAP     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_size,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [31:0] src_data,
    output logic        cnn_setup_en,
    output logic        cnn_in_valid,
    output logic [1:0]  cnn_action,
    output logic [1:0]  cnn_size,
    output logic [31:0] cnn_in_data,
    input  logic        cnn_out_valid,
    input  logic [31:0] cnn_out_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
`ifdef CNN_MASTER_RSP_SUM_EN
    output logic [31:0] rsp_sum,
`endif
    output logic        err,
    output logic [2:0]  err_code
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_arm   = 3'd1;
    localparam logic [2:0] c_st_issue = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_drain = 3'd4;
    localparam logic [2:0] c_st_gap   = 3'd5;

    localparam logic [2:0] c_op_setup = 3'd0;
    localparam logic [2:0] c_op_conv  = 3'd1;
    localparam logic [2:0] c_op_relu  = 3'd2;
    localparam logic [2:0] c_op_pool  = 3'd3;
    localparam logic [2:0] c_op_full  = 3'd4;

    localparam logic [2:0] c_err_none    = 3'd0;
    localparam logic [2:0] c_err_op      = 3'd1;
    localparam logic [2:0] c_err_nosetup = 3'd2;
    localparam logic [2:0] c_err_pool    = 3'd3;
    localparam logic [2:0] c_err_under   = 3'd4;
    localparam logic [2:0] c_err_tmo     = 3'd5;
    localparam logic [2:0] c_err_extra   = 3'd6;

    localparam int               c_tmo_w    = $clog2(TIMEOUT + 1);
    localparam int               c_gap_w    = $clog2(GAP + 2);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP - 1);
    localparam logic [2:0]       c_after_drain = (GAP == 0) ? c_st_idle : c_st_gap;

    // Element count N*N for a size code (0=16 .. 3=2).
    function automatic logic [8:0] sq(input logic [1:0] code);
        sq = 9'd256 >> {code, 1'b0};
    endfunction

    logic [2:0]         r_state;
    logic               r_cmd_ready;
    logic [2:0]         r_op;
    logic [1:0]         r_size;
    logic [1:0]         r_dim;
    logic               r_dim_ok;
    logic               r_first;
    logic [8:0]         r_cnt;
    logic [8:0]         r_burst_len;
    logic [8:0]         r_rsp_len;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic [c_gap_w-1:0] r_gap_cnt;

    logic [2:0] w_state_nxt;
    logic       w_accept, w_cmd_go, w_issue_hs, w_underrun, w_burst_done;
    logic       w_rsp_take, w_rsp_last, w_timeout, w_extra;
    logic [2:0] w_cmd_code;
    logic [1:0] w_post_dim, w_action;
    logic [8:0] w_burst_len, w_rsp_len;

    always_comb begin
        w_accept     = cmd_valid && r_cmd_ready;
        w_issue_hs   = (r_state == c_st_issue) && src_valid;
        w_underrun   = (r_state == c_st_issue) && !src_valid;
        w_burst_done = w_issue_hs && ((r_cnt + 9'd1) == r_burst_len);
        w_rsp_take   = ((r_state == c_st_wait) || (r_state == c_st_drain)) && cnn_out_valid;
        w_rsp_last   = w_rsp_take && ((r_cnt + 9'd1) == r_rsp_len);
        w_timeout    = (r_state == c_st_wait) && !cnn_out_valid && (r_tmo_cnt == c_tmo_last);
        w_extra      = cnn_out_valid && ((r_state == c_st_idle) || (r_state == c_st_arm) ||
                                         (r_state == c_st_gap));

        w_cmd_code = c_err_none;
        if (cmd_op > c_op_full)
            w_cmd_code = c_err_op;
        else if (!r_dim_ok && (cmd_op != c_op_setup))
            w_cmd_code = c_err_nosetup;
        else if ((cmd_op == c_op_pool) && (r_dim == 2'd3))
            w_cmd_code = c_err_pool;
        w_cmd_go = w_accept && (w_cmd_code == c_err_none);

        // Response length uses the dimension in effect once the op completes.
        w_post_dim  = r_dim;
        w_burst_len = 9'd1;
        case (cmd_op)
            c_op_setup: begin
                w_post_dim  = cmd_size;
                w_burst_len = sq(cmd_size);
            end
            c_op_conv: w_burst_len = 9'd9;
            c_op_pool: w_post_dim  = r_dim + 2'd1;
            c_op_full: w_burst_len = sq(r_dim);
            default:   ;
        endcase
        w_rsp_len = sq(w_post_dim);

        case (r_op)
            c_op_relu: w_action = 2'd1;
            c_op_pool: w_action = 2'd2;
            c_op_full: w_action = 2'd3;
            default:   w_action = 2'd0;
        endcase

        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_cmd_go) w_state_nxt = c_st_arm;
            c_st_arm:   if (src_valid) w_state_nxt = c_st_issue;
            c_st_issue: if (w_burst_done) w_state_nxt = c_st_wait;
            c_st_wait: begin
                if (w_rsp_last)      w_state_nxt = c_after_drain;
                else if (w_rsp_take) w_state_nxt = c_st_drain;
                else if (w_timeout)  w_state_nxt = c_st_idle;
            end
            c_st_drain: if (w_rsp_last) w_state_nxt = c_after_drain;
            c_st_gap:   if (r_gap_cnt == c_gap_last) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cmd_ready <= 1'b0;
            r_op        <= 3'd0;
            r_size      <= 2'd0;
            r_dim       <= 2'd0;
            r_dim_ok    <= 1'b0;
            r_first     <= 1'b0;
            r_cnt       <= 9'd0;
            r_burst_len <= 9'd0;
            r_rsp_len   <= 9'd0;
            r_tmo_cnt   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == c_st_idle);
            r_tmo_cnt   <= (r_state == c_st_wait) ? r_tmo_cnt + 1'b1 : '0;
            r_gap_cnt   <= (r_state == c_st_gap)  ? r_gap_cnt + 1'b1 : '0;
            if (w_cmd_go) begin
                r_op        <= cmd_op;
                r_size      <= cmd_size;
                r_first     <= 1'b1;
                r_cnt       <= 9'd0;
                r_burst_len <= w_burst_len;
                r_rsp_len   <= w_rsp_len;
                if (cmd_op == c_op_setup) begin
                    r_dim    <= cmd_size;
                    r_dim_ok <= 1'b1;
                end
            end else if (w_burst_done) begin
                r_cnt   <= 9'd0;
                r_first <= 1'b0;
            end else if (w_issue_hs || w_rsp_take) begin
                r_cnt   <= r_cnt + 9'd1;
                r_first <= 1'b0;
            end
            if (w_rsp_last && (r_op == c_op_pool))
                r_dim <= r_dim + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnn_setup_en <= 1'b0;
            cnn_in_valid <= 1'b0;
            cnn_action   <= 2'd0;
            cnn_size     <= 2'd0;
            cnn_in_data  <= 32'd0;
        end else if (w_issue_hs) begin
            cnn_setup_en <= (r_op == c_op_setup);
            cnn_in_valid <= (r_op != c_op_setup);
            cnn_action   <= r_first ? w_action : 2'd0;
            cnn_size     <= (r_first && (r_op == c_op_setup)) ? r_size : 2'd0;
            cnn_in_data  <= src_data;
        end else begin
            cnn_setup_en <= 1'b0;
            cnn_in_valid <= 1'b0;
            cnn_action   <= 2'd0;
            cnn_size     <= 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_last  <= 1'b0;
            err       <= 1'b0;
            err_code  <= c_err_none;
        end else begin
            rsp_valid <= w_rsp_take;
            rsp_last  <= w_rsp_last;
            if (w_rsp_take)
                rsp_data <= cnn_out_data;
            // err_code reports the most recent fault; err stays set until reset.
            if (w_accept && (w_cmd_code != c_err_none)) begin
                err      <= 1'b1;
                err_code <= w_cmd_code;
            end else if (w_underrun) begin
                err      <= 1'b1;
                err_code <= c_err_under;
            end else if (w_timeout) begin
                err      <= 1'b1;
                err_code <= c_err_tmo;
            end else if (w_extra) begin
                err      <= 1'b1;
                err_code <= c_err_extra;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign src_ready = (r_state == c_st_issue);

`ifdef CNN_MASTER_RSP_SUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rsp_sum <= 32'd0;
        else if (w_accept)
            rsp_sum <= 32'd0;
        else if (w_rsp_take)
            rsp_sum <= rsp_sum + cnn_out_data;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnn_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_cmd_master
// Purpose  : Scoreboard bench for cnn_cmd_master (CNN burst framing, result
//            return, error codes). Honours CNN_MASTER_RSP_SUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_cmd_master;

    localparam int TIMEOUT = 300;
    localparam int GAP     = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [1:0]  cmd_size = 2'd0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [31:0] src_data = 32'd0;
    logic        cnn_setup_en, cnn_in_valid;
    logic [1:0]  cnn_action, cnn_size;
    logic [31:0] cnn_in_data;
    logic        cnn_out_valid = 1'b0;
    logic [31:0] cnn_out_data = 32'd0;
    logic        rsp_valid, rsp_last;
    logic [31:0] rsp_data;
    logic        err;
    logic [2:0]  err_code;
`ifdef CNN_MASTER_RSP_SUM_EN
    logic [31:0] rsp_sum;
`endif

    cnn_cmd_master #(.TIMEOUT(TIMEOUT), .GAP(GAP)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_size(cmd_size),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .cnn_setup_en(cnn_setup_en), .cnn_in_valid(cnn_in_valid), .cnn_action(cnn_action),
        .cnn_size(cnn_size), .cnn_in_data(cnn_in_data),
        .cnn_out_valid(cnn_out_valid), .cnn_out_data(cnn_out_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
`ifdef CNN_MASTER_RSP_SUM_EN
        .rsp_sum(rsp_sum),
`endif
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        setup;
        logic [1:0]  act;
        logic [1:0]  sz;
    } cnn_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] sum;
    } rsp_t;

    cnn_t exp_cnn[$];
    rsp_t exp_rsp[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_strobe = 0;
    int n_src_hs = 0;
    int n_rsp    = 0;
    int setup_run = 0;
    int last_setup_run = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CNN-side scoreboard
    always @(negedge clk) begin : mon_cnn
        cnn_t e;
        if (src_valid && src_ready)
            n_src_hs++;
        if (cnn_setup_en) begin
            setup_run++;
        end else if (setup_run != 0) begin
            last_setup_run = setup_run;
            setup_run = 0;
        end
        if (cnn_setup_en || cnn_in_valid) begin
            n_strobe++;
            if (exp_cnn.size() == 0) begin
                check("cnn_unexpected", 1, 0);
            end else begin
                e = exp_cnn.pop_front();
                check("cnn_data",  cnn_in_data,  e.data);
                check("cnn_setup", cnn_setup_en, e.setup);
                check("cnn_inv",   cnn_in_valid, !e.setup);
                check("cnn_act",   cnn_action,   e.act);
                check("cnn_size",  cnn_size,     e.sz);
            end
        end else if ((cnn_action != 2'd0) || (cnn_size != 2'd0)) begin
            check("cnn_ctl_idle", {cnn_action, cnn_size}, 0);
        end
    end

    // Result-side scoreboard
    always @(negedge clk) begin : mon_rsp
        rsp_t r;
        if (rsp_valid) begin
            n_rsp++;
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                r = exp_rsp.pop_front();
                check("rsp_data", rsp_data, r.data);
                check("rsp_last", rsp_last, r.last);
`ifdef CNN_MASTER_RSP_SUM_EN
                if (r.last) check("rsp_sum", rsp_sum, r.sum);
`endif
            end
        end else if (rsp_last) begin
            check("rsp_last_idle", rsp_last, 0);
        end
    end

    task automatic apply_reset();
        cmd_valid = 1'b0; src_valid = 1'b0; cnn_out_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_err",   {err, err_code}, 0);
        check("rst_cnn",   {cnn_setup_en, cnn_in_valid, cnn_action, cnn_size}, 0);
        check("rst_ready", {cmd_ready, src_ready}, 0);
        check("rst_rsp",   {rsp_valid, rsp_last}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("ready_after_rst", cmd_ready, 1);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [1:0] sz);
        int t;
        t = 0;
        cmd_op = op; cmd_size = sz; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("cmd_ready_wait", 0, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
    endtask

    task automatic feed_src(input int n, input int base, input int hole_after,
                            input int hole_len, input logic setup,
                            input logic [1:0] act, input logic [1:0] sz);
        int k, t;
        bit hole_done;
        k = 0; t = 0; hole_done = 0;
        while (k < n && t < 1000) begin
            if (k == hole_after && !hole_done) begin
                hole_done = 1;
                src_valid = 1'b0;
                repeat (hole_len) @(posedge clk);
                #1;
            end
            src_valid = 1'b1;
            src_data  = base + k;
            @(negedge clk);
            if (src_ready) begin
                exp_cnn.push_back('{data: base + k, setup: setup,
                                    act: (k == 0) ? act : 2'd0,
                                    sz: (k == 0) ? sz : 2'd0});
                k++;
            end
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) check("src_feed_wait", k, n);
        src_valid = 1'b0;
    endtask

    task automatic cnn_echo(input int n, input int base, input int hole_at);
        logic [31:0] s;
        s = 0;
        for (int k = 0; k < n; k++) begin
            if (k == hole_at) begin
                cnn_out_valid = 1'b0;
                @(posedge clk); #1;
            end
            s = s + base + k;
            exp_rsp.push_back('{data: base + k, last: (k == n - 1), sum: s});
            cnn_out_valid = 1'b1;
            cnn_out_data  = base + k;
            @(posedge clk); #1;
        end
        cnn_out_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic queues_drained(input string tag);
        check({tag, "_cnn_q"}, exp_cnn.size(), 0);
        check({tag, "_rsp_q"}, exp_rsp.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int snap, t;
        apply_reset();

        // SETUP 4x4, 16 words, echoed back
        send_cmd(3'd0, 2'd2);
        feed_src(16, 1, -1, 0, 1'b1, 2'd0, 2'd2);
        cnn_echo(16, 1, -1);
        check("setup_run", last_setup_run, 16);
        check("setup_err", err, 0);
        queues_drained("setup");

        // POOL on 4x4 -> 2x2 response; second POOL at 2x2 must fail
        send_cmd(3'd3, 2'd0);
        feed_src(1, 32'hA5A5_0000, -1, 0, 1'b0, 2'd2, 2'd0);
        cnn_echo(4, 500, 2);
        check("pool_err", err, 0);
        queues_drained("pool");
        snap = n_strobe;
        send_cmd(3'd3, 2'd0);
        repeat (5) @(posedge clk);
        #1;
        check("pool2x2_err", {err, err_code}, {1'b1, 3'd3});
        check("pool2x2_nostrobe", n_strobe - snap, 0);
        check("pool2x2_ready", cmd_ready, 1);

        // CONV before any SETUP
        apply_reset();
        snap = n_strobe;
        send_cmd(3'd1, 2'd0);
        repeat (5) @(posedge clk);
        #1;
        check("nosetup_err", {err, err_code}, {1'b1, 3'd2});
        check("nosetup_nostrobe", n_strobe - snap, 0);

        // CONV with a 2-cycle source underrun after word 5
        apply_reset();
        send_cmd(3'd0, 2'd2);
        feed_src(16, 100, -1, 0, 1'b1, 2'd0, 2'd2);
        cnn_echo(16, 1000, -1);
        snap = n_src_hs;
        send_cmd(3'd1, 2'd0);
        feed_src(9, 200, 5, 2, 1'b0, 2'd0, 2'd0);
        check("underrun_hs", n_src_hs - snap, 9);
        cnn_echo(16, 2000, 7);
        check("underrun_err", {err, err_code}, {1'b1, 3'd4});
        queues_drained("conv");

        // SETUP 2x2, RELU, then FULL with a silent CNN
        apply_reset();
        send_cmd(3'd0, 2'd3);
        feed_src(4, 7, -1, 0, 1'b1, 2'd0, 2'd3);
        cnn_echo(4, 70, -1);
        send_cmd(3'd2, 2'd0);
        feed_src(1, 9, -1, 0, 1'b0, 2'd1, 2'd0);
        cnn_echo(4, 90, -1);
        check("relu_err", err, 0);
        send_cmd(3'd4, 2'd0);
        feed_src(4, 300, -1, 0, 1'b0, 2'd3, 2'd0);
        repeat (TIMEOUT - 10) @(posedge clk);
        #1 check("tmo_early", err, 0);
        t = 0;
        while (!err && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("tmo_err", {err, err_code}, {1'b1, 3'd5});
        check("tmo_ready", cmd_ready, 1);
        queues_drained("full");

        // Spurious CNN output in IDLE, then asynchronous reset clears errors
        apply_reset();
        snap = n_rsp;
        cnn_out_valid = 1'b1; cnn_out_data = 32'hDEAD_BEEF;
        @(posedge clk); #1 cnn_out_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("extra_err", {err, err_code}, {1'b1, 3'd6});
        check("extra_norsp", n_rsp - snap, 0);
        #2 rst = 1'b1;
        #1 check("async_rst_err", {err, err_code}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Illegal opcode
        send_cmd(3'd5, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_err", {err, err_code}, {1'b1, 3'd1});
        check("illegal_ready", cmd_ready, 1);
        queues_drained("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
